snac_string_fetch: RTL

Copies one fixed-length string from the SNAC string ROM into the character (text-overlay) buffer of the Analogizer debug display. The ROM is 21 strings × 32 bytes with a 1-cycle synchronous read. This block drives the ROM address, absorbs the read latency, and emits one character write per cycle at a caller-supplied buffer address. It stops at the NUL terminator, optionally space-padding the rest of the 32-byte field.

---
 rtl/snac_string_fetch.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/snac_string_fetch.sv
// Copies one 32-byte string from the SNAC string ROM into the debug-display
// character buffer: one write per cycle, stopping at NUL or space-padding the field.
module snac_string_fetch #(
  parameter int STR_LEN = 32,
  parameter int NUM_STR = 21,
  parameter int DST_AW  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        str_idx,
  input  logic [DST_AW-1:0] dst_addr,
  input  logic              pad_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [9:0]        rom_addr,
  input  logic [7:0]        rom_data,
  output logic              wr_en,
  output logic [DST_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam logic [4:0] LAST_POS  = 5'(STR_LEN - 1);
  localparam logic [4:0] NUM_STR_W = 5'(NUM_STR);
  localparam logic [7:0] PAD_CHAR  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_COPY  = 2'd2,
    ST_PAD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DST_AW-1:0] dst_q, dst_d;
  logic              pad_q, pad_d;
  logic [4:0]        wpos_q, wpos_d;
  logic [9:0]        rom_addr_q, rom_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [DST_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_req_s;
  logic [7:0]        wr_byte_s;

  function automatic logic [DST_AW-1:0] char_addr(input logic [DST_AW-1:0] base,
                                                  input logic [4:0]        pos);
    char_addr = base + {{(DST_AW-5){1'b0}}, pos};
  endfunction

  // Next-state, ROM address sequencing and write generation
  always_comb begin
    state_d    = state_q;
    dst_d      = dst_q;
    pad_d      = pad_q;
    wpos_d     = wpos_q;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_req_s   = 1'b0;
    wr_byte_s  = PAD_CHAR;

    // Prefetch runs one byte ahead of wpos and must never leave the string.
    if (state_q != ST_IDLE) begin
      if (rom_addr_q[4:0] != LAST_POS) begin
        rom_addr_d = rom_addr_q + 10'd1;
      end else begin
        rom_addr_d = rom_addr_q;
      end
    end else begin
      rom_addr_d = rom_addr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (str_idx < NUM_STR_W) begin
            dst_d      = dst_addr;
            pad_d      = pad_en;
            wpos_d     = 5'd0;
            rom_addr_d = {str_idx, 5'd0};
            state_d    = ST_PRIME;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        state_d = ST_COPY;
      end
      ST_COPY: begin
        if (rom_data != 8'h00) begin
          wr_req_s  = 1'b1;
          wr_byte_s = rom_data;
        end else if (pad_q) begin
          wr_req_s  = 1'b1;
          wr_byte_s = PAD_CHAR;
          state_d   = ST_PAD;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PAD: begin
        wr_req_s  = 1'b1;
        wr_byte_s = PAD_CHAR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wr_req_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = char_addr(dst_q, wpos_q);
      wr_data_d = wr_byte_s;
      wpos_d    = wpos_q + 5'd1;
      if (wpos_q == LAST_POS) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        done_d = done_d;
      end
    end else begin
      wr_en_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dst_q      <= '0;
      pad_q      <= 1'b0;
      wpos_q     <= 5'd0;
      rom_addr_q <= 10'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      pad_q      <= pad_d;
      wpos_q     <= wpos_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rom_addr = rom_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
